sound_playback_sched: RTL and testbench

Schedules shared access to the single audio sample ROM port (16-bit half-word reads, 32-bit address, registered dout) among NUM_CH sound channels, e.g. soundtrack and effects. Each sample_tick, it reads one sample from every active channel in turn. It sums the samples with saturation and emits one mixed sample to the audio codec path. Per channel, it tracks the sample index, wrap at depth, and repeat count.

---
 rtl/sound_pkg.sv | 26 ++
 rtl/sound_channel_seq.sv | 48 ++++
 rtl/sound_playback_sched.sv | 133 +++++++++++++
 tb/tb_sound_playback_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared definitions for the sound playback scheduler: channel IDs, ROM base
// addresses per channel, scheduler FSM states and the 16-bit saturation helper.
// No ports; imported by sound_playback_sched and sound_channel_seq.
package sound_pkg;

  localparam int NUM_CH        = 2;
  localparam int CH_SOUNDTRACK = 0;
  localparam int CH_SHOT       = 1;
  localparam int DEPTH_W       = 18;

  // Half-word base address of each channel's sample block; slice i = channel i.
  localparam logic [NUM_CH-1:0][31:0] BASE = {32'h0001_0000, 32'h0000_0000};

  typedef enum logic [2:0] {IDLE, SCAN, WAIT, CAPTURE, OUT} sched_state_t;

  // Clamp a 17-bit signed sum to the 16-bit signed range. Overflow shows up as
  // the two top bits disagreeing; the sign bit tells which rail to pick.
  function automatic logic [15:0] sat16(input logic [16:0] v);
    logic [15:0] r;
    if (v[16] == v[15]) r = v[15:0];
    else if (v[16])     r = 16'h8000;
    else                r = 16'h7FFF;
    return r;
  endfunction

endpackage

// File: rtl/sound_channel_seq.sv
// Per-channel playback state: sample index, completed-pass count, active flag.
// Ports: play/stop/advance strobes, live depth and repeat count in; idx and
// active out. Priority: stop > play > advance (a restart beats end-of-sound).
module sound_channel_seq #(
  parameter int DEPTH_W = 18
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               play,
  input  logic               stop,
  input  logic               advance,
  input  logic [DEPTH_W-1:0] depth,
  input  logic [31:0]        repeats,
  output logic [DEPTH_W-1:0] idx,
  output logic               active
);

  logic [31:0] rep;
  logic        at_end;
  logic        last_pass;

  assign at_end    = (idx == depth - DEPTH_W'(1));
  assign last_pass = (repeats != 32'd0) && (rep + 32'd1 == repeats);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      idx    <= '0;
      rep    <= '0;
      active <= 1'b0;
    end else if (stop) begin
      active <= 1'b0;
    end else if (play && (depth != '0)) begin
      // A zero-length sound is never started.
      idx    <= '0;
      rep    <= '0;
      active <= 1'b1;
    end else if (advance && active) begin
      if (at_end) begin
        idx <= '0;
        rep <= rep + 32'd1;
        if (last_pass) active <= 1'b0;
      end else begin
        idx <= idx + DEPTH_W'(1);
      end
    end
  end

endmodule

// File: rtl/sound_playback_sched.sv
// Per sample_tick, reads one sample per active channel from the shared ROM port,
// sums them with saturation and strobes sample_valid with the mixed result.
// Ports: clk/resetN, sample_tick, play_req/stop_all, ch_depth/ch_repeats,
// rom_addr/rom_dout, sample_out/sample_valid, ch_active, sticky overrun.
module sound_playback_sched #(
  parameter int NUM_CH  = sound_pkg::NUM_CH,
  parameter int ROM_LAT = 3,
  parameter int ADDR_W  = 32,
  parameter int DEPTH_W = sound_pkg::DEPTH_W
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      sample_tick,
  input  logic [NUM_CH-1:0]         play_req,
  input  logic                      stop_all,
  input  logic [NUM_CH*DEPTH_W-1:0] ch_depth,
  input  logic [NUM_CH*32-1:0]      ch_repeats,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [15:0]               rom_dout,
  output logic [15:0]               sample_out,
  output logic                      sample_valid,
  output logic [NUM_CH-1:0]         ch_active,
  output logic                      overrun
);

  import sound_pkg::*;

  localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WCNT_W = $clog2(ROM_LAT + 1);

  sched_state_t       state, state_nxt;
  logic [PTR_W-1:0]   ch_ptr, ptr_nxt;
  logic [WCNT_W-1:0]  wait_cnt, wcnt_nxt;
  logic [16:0]        acc, acc_nxt;
  logic               addr_ld;
  logic [NUM_CH-1:0]  adv;
  logic               last_ch;
  logic [DEPTH_W-1:0] idx [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sound_channel_seq #(.DEPTH_W(DEPTH_W)) u_seq (
      .clk     (clk),
      .resetN  (resetN),
      .play    (play_req[i]),
      .stop    (stop_all),
      .advance (adv[i]),
      .depth   (ch_depth[i*DEPTH_W +: DEPTH_W]),
      .repeats (ch_repeats[i*32 +: 32]),
      .idx     (idx[i]),
      .active  (ch_active[i])
    );
  end

  assign last_ch = (ch_ptr == PTR_W'(NUM_CH - 1));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ch_ptr;
    wcnt_nxt  = wait_cnt;
    acc_nxt   = acc;
    addr_ld   = 1'b0;
    adv       = '0;
    unique case (state)
      IDLE: begin
        if (sample_tick) begin
          acc_nxt   = '0;
          ptr_nxt   = '0;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        // ch_active is sampled here, so a play_req landing before the scan
        // reaches a channel gets that channel read on this tick.
        if (ch_active[ch_ptr]) begin
          addr_ld   = 1'b1;
          wcnt_nxt  = '0;
          state_nxt = WAIT;
        end else if (last_ch) begin
          state_nxt = OUT;
        end else begin
          ptr_nxt = ch_ptr + PTR_W'(1);
        end
      end
      WAIT: begin
        if (wait_cnt == WCNT_W'(ROM_LAT - 1)) state_nxt = CAPTURE;
        else                                  wcnt_nxt  = wait_cnt + WCNT_W'(1);
      end
      CAPTURE: begin
        acc_nxt     = acc + {rom_dout[15], rom_dout};
        adv[ch_ptr] = 1'b1;
        if (last_ch) begin
          state_nxt = OUT;
        end else begin
          ptr_nxt   = ch_ptr + PTR_W'(1);
          state_nxt = SCAN;
        end
      end
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output sample and strobe are loaded on entry to OUT so both are visible
  // during the OUT cycle itself.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ch_ptr       <= '0;
      wait_cnt     <= '0;
      acc          <= '0;
      rom_addr     <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      ch_ptr       <= ptr_nxt;
      wait_cnt     <= wcnt_nxt;
      acc          <= acc_nxt;
      sample_valid <= (state_nxt == OUT);
      if (addr_ld)
        rom_addr <= ADDR_W'(BASE[ch_ptr]) + ADDR_W'(idx[ch_ptr]);
      if (state_nxt == OUT)
        sample_out <= sat16(acc_nxt);
      if (sample_tick && (state != IDLE))
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sound_playback_sched.sv
// Directed bench for sound_playback_sched: ROM model with ROM_LAT-cycle delay,
// per-scenario tasks with inline hand-computed expectations.
module tb_sound_playback_sched;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        sample_tick = 1'b0;
  logic [1:0]  play_req = 2'b00;
  logic        stop_all = 1'b0;
  logic [17:0] depth0 = '0, depth1 = '0;
  logic [31:0] rep0 = '0, rep1 = '0;
  logic [31:0] rom_addr;
  logic [15:0] rom_dout;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic [1:0]  ch_active;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int v0_base = 0;
  int v1_base = 0;

  sound_playback_sched dut (
    .clk          (clk),
    .resetN       (resetN),
    .sample_tick  (sample_tick),
    .play_req     (play_req),
    .stop_all     (stop_all),
    .ch_depth     ({depth1, depth0}),
    .ch_repeats   ({rep1, rep0}),
    .rom_addr     (rom_addr),
    .rom_dout     (rom_dout),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .ch_active    (ch_active),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // ROM contents: channel block base value plus the low address byte.
  function automatic logic [15:0] rom_fn(input logic [31:0] a);
    int v;
    v = (a[16] ? v1_base : v0_base) + int'(a[7:0]);
    return v[15:0];
  endfunction

  // Three-stage registered read: data valid three edges after an address change.
  logic [15:0] rp0 = '0, rp1 = '0, rp2 = '0;
  always @(posedge clk) begin
    rp0 <= rom_fn(rom_addr);
    rp1 <= rp0;
    rp2 <= rp1;
  end
  assign rom_dout = rp2;

  always @(negedge clk) if (sample_valid) valid_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse(input logic [1:0] pmask, input logic stop);
    @(negedge clk);
    play_req = pmask;
    stop_all = stop;
    @(negedge clk);
    play_req = 2'b00;
    stop_all = 1'b0;
  endtask

  // Tick, then count negedges until sample_valid (lat = cycles after tick).
  // Optionally pulses play_req during cycle tick+play_at.
  task automatic do_tick(input int play_at, input logic [1:0] pmask, output int lat);
    @(negedge clk);
    sample_tick = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      sample_tick = 1'b0;
      play_req = (lat == play_at) ? pmask : 2'b00;
    end while (!sample_valid && lat < 40);
    play_req = 2'b00;
  endtask

  task automatic test_reset();
    #3 resetN = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rom_addr !== 32'd0) begin errors++; $display("FAIL reset_rom_addr got %0h want 0", rom_addr); end
    checks++; if (sample_out !== 16'd0) begin errors++; $display("FAIL reset_sample_out got %0h want 0", sample_out); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_sample_valid got %b want 0", sample_valid); end
    checks++; if (ch_active !== 2'b00) begin errors++; $display("FAIL reset_ch_active got %b want 00", ch_active); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_repeat_end();
    int lat;
    v0_base = 10; v1_base = 0;
    depth0 = 18'd4; rep0 = 32'd2; depth1 = 18'd0; rep1 = 32'd0;
    pulse(2'b01, 1'b0);
    checks++; if (ch_active !== 2'b01) begin errors++; $display("FAIL rep_start_active got %b want 01", ch_active); end
    for (int i = 0; i < 8; i++) begin
      do_tick(0, 2'b00, lat);
      checks++; if (lat !== 7) begin errors++; $display("FAIL rep_latency tick %0d got %0d want 7", i, lat); end
      checks++; if (rom_addr !== 32'(i % 4)) begin errors++; $display("FAIL rep_addr tick %0d got %0h want %0h", i, rom_addr, i % 4); end
      checks++; if (sample_out !== 16'(10 + i % 4)) begin errors++; $display("FAIL rep_sample tick %0d got %0d want %0d", i, $signed(sample_out), 10 + i % 4); end
      if (i == 6) begin
        checks++; if (ch_active !== 2'b01) begin errors++; $display("FAIL rep_still_active got %b want 01", ch_active); end
      end
    end
    checks++; if (ch_active !== 2'b00) begin errors++; $display("FAIL rep_end_inactive got %b want 00", ch_active); end
    for (int i = 0; i < 2; i++) begin
      do_tick(0, 2'b00, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL idle_latency got %0d want 3", lat); end
      checks++; if (sample_out !== 16'd0) begin errors++; $display("FAIL idle_sample got %0d want 0", $signed(sample_out)); end
      checks++; if (rom_addr !== 32'd3) begin errors++; $display("FAIL idle_addr_hold got %0h want 3", rom_addr); end
    end
  endtask

  task automatic test_saturation();
    int lat;
    depth0 = 18'd4; rep0 = 32'd0; depth1 = 18'd4; rep1 = 32'd0;
    v0_base = 30000; v1_base = 10000;
    pulse(2'b11, 1'b0);
    do_tick(0, 2'b00, lat);
    checks++; if (lat !== 11) begin errors++; $display("FAIL sat_latency got %0d want 11", lat); end
    checks++; if (sample_out !== 16'h7FFF) begin errors++; $display("FAIL sat_pos got %0d want 32767", $signed(sample_out)); end
    checks++; if (rom_addr !== 32'h0001_0000) begin errors++; $display("FAIL sat_last_addr got %0h want 10000", rom_addr); end
    pulse(2'b00, 1'b1);
    v0_base = -30000; v1_base = -10000;
    pulse(2'b11, 1'b0);
    do_tick(0, 2'b00, lat);
    checks++; if (lat !== 11) begin errors++; $display("FAIL sat_neg_latency got %0d want 11", lat); end
    checks++; if (sample_out !== 16'h8000) begin errors++; $display("FAIL sat_neg got %0d want -32768", $signed(sample_out)); end
    do_tick(0, 2'b00, lat);
    v0_base = 1000; v1_base = -3000;
    do_tick(0, 2'b00, lat);
    checks++; if (sample_out !== 16'(-1996)) begin errors++; $display("FAIL mix_plain got %0d want -1996", $signed(sample_out)); end
    checks++; if (rom_addr !== 32'h0001_0002) begin errors++; $display("FAIL mix_addr got %0h want 10002", rom_addr); end
  endtask

  task automatic test_loop_forever();
    int lat;
    pulse(2'b00, 1'b1);
    v0_base = 10;
    depth0 = 18'd3; rep0 = 32'd0;
    pulse(2'b01, 1'b0);
    for (int i = 0; i < 7; i++) begin
      do_tick(0, 2'b00, lat);
      checks++; if (rom_addr !== 32'(i % 3)) begin errors++; $display("FAIL loop_addr tick %0d got %0h want %0h", i, rom_addr, i % 3); end
      checks++; if (lat !== 7) begin errors++; $display("FAIL loop_latency tick %0d got %0d want 7", i, lat); end
    end
    checks++; if (ch_active !== 2'b01) begin errors++; $display("FAIL loop_active got %b want 01", ch_active); end
  endtask

  task automatic test_overrun();
    int lat, vstart, nval;
    logic [15:0] got;
    pulse(2'b00, 1'b1);
    depth0 = 18'd4; rep0 = 32'd0; depth1 = 18'd4; rep1 = 32'd0;
    v0_base = 100; v1_base = 200;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_pre got %b want 0", overrun); end
    pulse(2'b11, 1'b0);
    vstart = valid_cnt;
    got = 16'hDEAD;
    @(negedge clk) sample_tick = 1'b1;
    @(negedge clk) sample_tick = 1'b0;
    @(negedge clk) sample_tick = 1'b1;
    @(negedge clk) sample_tick = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (sample_valid) got = sample_out;
    end
    nval = valid_cnt - vstart;
    checks++; if (nval !== 1) begin errors++; $display("FAIL ovr_valid_count got %0d want 1", nval); end
    checks++; if (got !== 16'd300) begin errors++; $display("FAIL ovr_sample got %0d want 300", $signed(got)); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", overrun); end
    do_tick(0, 2'b00, lat);
    checks++; if (lat !== 11) begin errors++; $display("FAIL ovr_next_latency got %0d want 11", lat); end
    checks++; if (sample_out !== 16'd302) begin errors++; $display("FAIL ovr_next_sample got %0d want 302", $signed(sample_out)); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun); end
  endtask

  task automatic test_play_priority();
    int lat;
    pulse(2'b00, 1'b1);
    depth0 = 18'd2; rep0 = 32'd1; depth1 = 18'd4; rep1 = 32'd0;
    v0_base = 10;
    pulse(2'b01, 1'b0);
    do_tick(0, 2'b00, lat);
    checks++; if (sample_out !== 16'd10) begin errors++; $display("FAIL pp_first got %0d want 10", $signed(sample_out)); end
    // Capture of the final sample happens in cycle tick+5; restart there.
    do_tick(5, 2'b01, lat);
    checks++; if (sample_out !== 16'd11) begin errors++; $display("FAIL pp_last_sample got %0d want 11", $signed(sample_out)); end
    checks++; if (ch_active !== 2'b01) begin errors++; $display("FAIL pp_stays_active got %b want 01", ch_active); end
    do_tick(0, 2'b00, lat);
    checks++; if (rom_addr !== 32'd0) begin errors++; $display("FAIL pp_restart_addr got %0h want 0", rom_addr); end
    checks++; if (sample_out !== 16'd10) begin errors++; $display("FAIL pp_restart_sample got %0d want 10", $signed(sample_out)); end
    pulse(2'b10, 1'b1);
    checks++; if (ch_active !== 2'b00) begin errors++; $display("FAIL stop_beats_play got %b want 00", ch_active); end
  endtask

  task automatic test_reset_mid_wait();
    int lat, vstart, nval;
    depth1 = 18'd4; rep1 = 32'd0;
    v1_base = 500;
    pulse(2'b10, 1'b0);
    @(negedge clk) sample_tick = 1'b1;
    @(negedge clk) sample_tick = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rom_addr !== 32'h0001_0000) begin errors++; $display("FAIL rw_addr_before got %0h want 10000", rom_addr); end
    #2 resetN = 1'b0;
    #1;
    checks++; if (rom_addr !== 32'd0) begin errors++; $display("FAIL rw_rom_addr got %0h want 0", rom_addr); end
    checks++; if (sample_out !== 16'd0) begin errors++; $display("FAIL rw_sample_out got %0h want 0", sample_out); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rw_sample_valid got %b want 0", sample_valid); end
    checks++; if (ch_active !== 2'b00) begin errors++; $display("FAIL rw_ch_active got %b want 00", ch_active); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rw_overrun got %b want 0", overrun); end
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    vstart = valid_cnt;
    repeat (20) @(negedge clk);
    nval = valid_cnt - vstart;
    checks++; if (nval !== 0) begin errors++; $display("FAIL rw_no_valid got %0d want 0", nval); end
    do_tick(0, 2'b00, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rw_idle_latency got %0d want 3", lat); end
    checks++; if (sample_out !== 16'd0) begin errors++; $display("FAIL rw_idle_sample got %0d want 0", $signed(sample_out)); end
  endtask

  initial begin
    test_reset();
    test_repeat_end();
    test_saturation();
    test_loop_forever();
    test_overrun();
    test_play_priority();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
